seg_scan_driver: RTL

//  Parametrised multiplexed 7-segment scanner: per-digit latched hex nibbles + decimal points, time-multiplexed onto
//  one shared segment bus and SEG_NUM digit selects. Adds hex decode, leading-zero blanking, PWM brightness and

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_hex_decode.sv | 38 +++
 rtl/seg_scan_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
//   Glyph0..GlyphF : active-high {a,b,c,d,e,f,g} patterns for hex digits 0-F
//   SegOff         : active-high 8-bit pattern with every segment and dp dark
//   seg_polarity() : maps an active-high segment byte onto the pin polarity
package seg_pkg;

  localparam logic [6:0] Glyph0 = 7'b1111110;
  localparam logic [6:0] Glyph1 = 7'b0110000;
  localparam logic [6:0] Glyph2 = 7'b1101101;
  localparam logic [6:0] Glyph3 = 7'b1111001;
  localparam logic [6:0] Glyph4 = 7'b0110011;
  localparam logic [6:0] Glyph5 = 7'b1011011;
  localparam logic [6:0] Glyph6 = 7'b1011111;
  localparam logic [6:0] Glyph7 = 7'b1110000;
  localparam logic [6:0] Glyph8 = 7'b1111111;
  localparam logic [6:0] Glyph9 = 7'b1111011;
  localparam logic [6:0] GlyphA = 7'b1110111;
  localparam logic [6:0] GlyphB = 7'b0011111;
  localparam logic [6:0] GlyphC = 7'b1001110;
  localparam logic [6:0] GlyphD = 7'b0111101;
  localparam logic [6:0] GlyphE = 7'b1001111;
  localparam logic [6:0] GlyphF = 7'b1000111;

  localparam logic [7:0] SegOff = 8'h00;

  function automatic logic [7:0] seg_polarity(input logic [7:0] seg, input bit act_low);
    return act_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-7-segment decoder.
//   nib_i   : hex nibble 0-F
//   dp_i    : decimal point request
//   glyph_o : active-high {a,b,c,d,e,f,g,dp}; bit7 = a, bit0 = dp
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] glyph_o
);

  logic [6:0] seg7;

  always_comb begin
    seg7 = Glyph0;
    unique case (nib_i)
      4'h0: seg7 = Glyph0;
      4'h1: seg7 = Glyph1;
      4'h2: seg7 = Glyph2;
      4'h3: seg7 = Glyph3;
      4'h4: seg7 = Glyph4;
      4'h5: seg7 = Glyph5;
      4'h6: seg7 = Glyph6;
      4'h7: seg7 = Glyph7;
      4'h8: seg7 = Glyph8;
      4'h9: seg7 = Glyph9;
      4'hA: seg7 = GlyphA;
      4'hB: seg7 = GlyphB;
      4'hC: seg7 = GlyphC;
      4'hD: seg7 = GlyphD;
      4'hE: seg7 = GlyphE;
      4'hF: seg7 = GlyphF;
    endcase
    glyph_o = {seg7, dp_i};
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner: latches per-digit nibbles and decimal points, then
// time-multiplexes them onto one segment bus with hex decode, leading-zero blanking,
// PWM brightness and configurable pin polarity.
// Optional feature: define SEG_BLINK_EN to add the blink port and BLINK_SLOTS parameter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din/din_vld : nibble i at din[4*i+3:4*i], loaded with dp_in[i] when din_vld[i] is set
//   lz_en       : blank leading zero digits (digit 0 always shown)
//   brightness  : PWM duty, 0 = dark, all-ones = full on
//   blink       : (SEG_BLINK_EN) per-digit blink request
//   segment     : {a..g,dp} pins; segsel: digit enables; frame_tick: end-of-frame pulse
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SEG_NUM     = 4,
  parameter int unsigned SCAN_CYC    = 50_000,
  parameter int unsigned BRT_W       = 3,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          SEL_ACT_LOW = 1'b1
`ifdef SEG_BLINK_EN
  ,
  parameter int unsigned BLINK_SLOTS = 256
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*SEG_NUM-1:0] din,
  input  logic [SEG_NUM-1:0]   din_vld,
  input  logic [SEG_NUM-1:0]   dp_in,
  input  logic                 lz_en,
  input  logic [BRT_W-1:0]     brightness,
`ifdef SEG_BLINK_EN
  input  logic [SEG_NUM-1:0]   blink,
`endif
  output logic [7:0]           segment,
  output logic [SEG_NUM-1:0]   segsel,
  output logic                 frame_tick
);

  localparam int unsigned SubCyc = SCAN_CYC >> BRT_W;
  localparam int unsigned SubW   = (SubCyc > 1) ? $clog2(SubCyc) : 1;
  localparam int unsigned SelW   = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
  localparam logic [BRT_W-1:0]   BrtFull = '1;
  localparam logic [7:0]         SegIdle = seg_polarity(SegOff, SEG_ACT_LOW);
  localparam logic [SEG_NUM-1:0] SelIdle = SEL_ACT_LOW ? '1 : '0;

  logic [4*SEG_NUM-1:0] nib_q, nib_d;
  logic [SEG_NUM-1:0]   dp_q, dp_d;
  logic [SubW-1:0]      sub_cnt_q, sub_cnt_d;
  logic [BRT_W-1:0]     pwm_idx_q, pwm_idx_d;
  logic [SelW-1:0]      sel_cnt_q, sel_cnt_d;
  logic [3:0]           snap_nib_q, snap_nib_d;
  logic                 snap_dp_q, snap_dp_d;
  logic                 snap_blank_q, snap_blank_d;
  logic [BRT_W-1:0]     snap_brt_q, snap_brt_d;
  logic [7:0]           segment_q, segment_d;
  logic [SEG_NUM-1:0]   segsel_q, segsel_d;
  logic                 frame_tick_q, frame_tick_d;

  logic sub_last, slot_wrap, slot_start, sel_last, frame_wrap;
  logic zero_above, blink_off, lit;
  logic [SEG_NUM-1:0] lz_blank, sel_oh;
  logic [7:0] glyph;

  // The slot counter is split into sub-period and PWM index so no divider is needed.
  always_comb begin
    sub_last   = (sub_cnt_q == SubW'(SubCyc - 1));
    slot_wrap  = sub_last && (pwm_idx_q == BrtFull);
    slot_start = (sub_cnt_q == '0) && (pwm_idx_q == '0);
    sel_last   = (sel_cnt_q == SelW'(SEG_NUM - 1));
    frame_wrap = slot_wrap && sel_last;
    sub_cnt_d  = sub_last ? '0 : sub_cnt_q + 1'b1;
    pwm_idx_d  = sub_last ? pwm_idx_q + 1'b1 : pwm_idx_q;
    sel_cnt_d  = sel_cnt_q;
    if (slot_wrap) sel_cnt_d = sel_last ? '0 : sel_cnt_q + 1'b1;
  end

  always_comb begin
    nib_d = nib_q;
    dp_d  = dp_q;
    for (int i = 0; i < SEG_NUM; i++) begin
      if (din_vld[i]) begin
        nib_d[4*i +: 4] = din[4*i +: 4];
        dp_d[i]         = dp_in[i];
      end
    end
  end

  // Digit i is a leading zero when it and every digit above it hold zero.
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = SEG_NUM - 1; i >= 0; i--) begin
      zero_above  = zero_above && (nib_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_en && zero_above && (i != 0);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BcW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  logic [BcW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_wrap) begin
      if (blink_cnt_q == BcW'(BLINK_SLOTS - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    blink_off = blink[sel_cnt_q] && !blink_on_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`else
  assign blink_off = 1'b0;
`endif

  // Snapshot at slot start and use the fresh values on that same edge, so the digit's
  // data, segments and select all switch together.
  always_comb begin
    snap_nib_d   = snap_nib_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    snap_brt_d   = snap_brt_q;
    if (slot_start) begin
      snap_nib_d   = nib_q[4*int'(sel_cnt_q) +: 4];
      snap_dp_d    = dp_q[sel_cnt_q];
      snap_blank_d = lz_blank[sel_cnt_q] || blink_off;
      snap_brt_d   = brightness;
    end
  end

  seg_hex_decode u_dec (
    .nib_i   (snap_nib_d),
    .dp_i    (snap_dp_d),
    .glyph_o (glyph)
  );

  always_comb begin
    lit    = !snap_blank_d && ((snap_brt_d == BrtFull) || (pwm_idx_q < snap_brt_d));
    sel_oh = '0;
    if (lit) sel_oh[sel_cnt_q] = 1'b1;
    segment_d    = seg_polarity(lit ? glyph : SegOff, SEG_ACT_LOW);
    segsel_d     = SEL_ACT_LOW ? ~sel_oh : sel_oh;
    frame_tick_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q        <= '0;
      dp_q         <= '0;
      sub_cnt_q    <= '0;
      pwm_idx_q    <= '0;
      sel_cnt_q    <= '0;
      snap_nib_q   <= '0;
      snap_dp_q    <= 1'b0;
      snap_blank_q <= 1'b0;
      snap_brt_q   <= '0;
      segment_q    <= SegIdle;
      segsel_q     <= SelIdle;
      frame_tick_q <= 1'b0;
    end else begin
      nib_q        <= nib_d;
      dp_q         <= dp_d;
      sub_cnt_q    <= sub_cnt_d;
      pwm_idx_q    <= pwm_idx_d;
      sel_cnt_q    <= sel_cnt_d;
      snap_nib_q   <= snap_nib_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      snap_brt_q   <= snap_brt_d;
      segment_q    <= segment_d;
      segsel_q     <= segsel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign segment    = segment_q;
  assign segsel     = segsel_q;
  assign frame_tick = frame_tick_q;

endmodule
